// File: rtl/als_sample_filter_if.sv
// als_sample_filter_if: control, reader handshake and result signals of the ALS sample filter
interface als_sample_filter_if;
  logic enable;
  logic [7:0] threshold;
  logic clear_err;
  logic als_done;
  logic [31:0] als_data;
  logic als_trigger;
  logic als_oe;
  logic [7:0] avg;
  logic avg_valid;
  logic dark;
  logic timeout_err;
  modport master (
    output enable, threshold, clear_err, als_done, als_data,
    input  als_trigger, als_oe, avg, avg_valid, dark, timeout_err
  );
  modport slave (
    input  enable, threshold, clear_err, als_done, als_data,
    output als_trigger, als_oe, avg, avg_valid, dark, timeout_err
  );
endinterface

// File: rtl/als_sample_filter.sv
// als_sample_filter: paces ALS reads, averages 2^AVG_LOG2 samples, derives hysteretic dark flag
module als_sample_filter #(
  parameter logic [31:0] SAMPLE_PERIOD = 32'd100_000,
  parameter int          AVG_LOG2      = 3,
  parameter logic [31:0] TIMEOUT       = 32'd20_000,
  parameter logic [7:0]  HYST          = 8'd4
) (
  input logic clk,
  input logic rst,
  als_sample_filter_if.slave s
);
  localparam int AW = 8 + AVG_LOG2;
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_DONE, CAPTURE, ACCUM, WAIT_PERIOD} state_t;
  state_t state;
  logic [AW-1:0] acc, acc_new;
  logic [AVG_LOG2-1:0] cnt;
  logic [31:0] pcnt, tcnt;
  logic [7:0] sample, avg_new, thr_hi;
  logic [8:0] thr_sum;
  logic cap_ph;
  logic unused_data;
  assign unused_data = ^s.als_data[31:8];
  always_comb begin
    acc_new = acc + AW'(sample);
    avg_new = acc_new[AW-1:AVG_LOG2];
    thr_sum = {1'b0, s.threshold} + {1'b0, HYST};
    thr_hi  = thr_sum[8] ? 8'hff : thr_sum[7:0];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      s.als_trigger <= 1'b0;
      s.als_oe      <= 1'b0;
      s.avg         <= '0;
      s.avg_valid   <= 1'b0;
      s.dark        <= 1'b0;
      s.timeout_err <= 1'b0;
      acc           <= '0;
      cnt           <= '0;
      pcnt          <= '0;
      tcnt          <= '0;
      sample        <= '0;
      cap_ph        <= 1'b0;
    end else begin
      s.avg_valid <= 1'b0;
      if (s.clear_err) s.timeout_err <= 1'b0;
      case (state)
        IDLE: if (s.enable) begin
          state         <= TRIG;
          s.als_trigger <= 1'b1;
        end
        TRIG: begin
          s.als_trigger <= 1'b1;
          tcnt          <= 32'd1;
          if (!s.als_done) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          tcnt <= tcnt + 32'd1;
          if (s.als_done) begin
            s.als_trigger <= 1'b0;
            s.als_oe      <= 1'b1;
            cap_ph        <= 1'b0;
            state         <= CAPTURE;
          end else if (tcnt + 32'd1 >= TIMEOUT) begin
            // abandoned read: sample discarded, set overrides a concurrent clear
            s.als_trigger <= 1'b0;
            s.timeout_err <= 1'b1;
            pcnt          <= '0;
            state         <= WAIT_PERIOD;
          end
        end
        CAPTURE: begin
          cap_ph <= 1'b1;
          if (cap_ph) begin
            sample   <= s.als_data[7:0];
            s.als_oe <= 1'b0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          acc   <= acc_new;
          cnt   <= cnt + AVG_LOG2'(1);
          pcnt  <= '0;
          state <= WAIT_PERIOD;
          if (&cnt) begin
            acc         <= '0;
            s.avg       <= avg_new;
            s.avg_valid <= 1'b1;
            if (avg_new < s.threshold) s.dark <= 1'b1;
            else if (avg_new >= thr_hi) s.dark <= 1'b0;
          end
        end
        WAIT_PERIOD: begin
          if (pcnt + 32'd1 >= SAMPLE_PERIOD) begin
            if (s.enable) begin
              state         <= TRIG;
              s.als_trigger <= 1'b1;
            end else begin
              state <= IDLE;
              acc   <= '0;
              cnt   <= '0;
            end
          end else pcnt <= pcnt + 32'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_als_sample_filter.sv
// tb_als_sample_filter: behavioural ALS reader plus averaging/dark reference model for als_sample_filter
module tb_als_sample_filter;
  localparam int RD_DELAY = 20;
  localparam int S_TRIG = 0, S_AVG = 1, S_OE = 2, S_TERR = 3;
  logic clk = 1'b0;
  logic rst;
  als_sample_filter_if vif();
  als_sample_filter #(
    .SAMPLE_PERIOD(32'd50), .AVG_LOG2(2), .TIMEOUT(32'd40), .HYST(8'd4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s(vif)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  int served = 0, age = 0, stale_left = 0, rd_stale = 0;
  bit rd_never = 1'b0;
  bit m_dark = 1'b0;
  logic [7:0] rd_q[$];
  int grp[$];
  int exp_q[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  function automatic logic sig_val(input int sel);
    case (sel)
      S_TRIG:  return vif.als_trigger;
      S_AVG:   return vif.avg_valid;
      S_OE:    return vif.als_oe;
      default: return vif.timeout_err;
    endcase
  endfunction
  task automatic wait_for(input int sel, input logic val, input int budget, output int n);
    n = 0;
    while (sig_val(sel) !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic avg_group(input logic [7:0] a, b, c, d, input string tag);
    int n;
    rd_q.push_back(a);
    rd_q.push_back(b);
    rd_q.push_back(c);
    rd_q.push_back(d);
    wait_for(S_AVG, 1'b1, 600, n);
    chk({tag, "_pulse"}, 32'(n < 600), 32'd1);
    @(negedge clk);
  endtask
  // reader: done rises RD_DELAY clocks into a trigger, held until trigger drops (plus optional stale hold)
  initial begin
    logic [7:0] v;
    int sum;
    vif.als_done = 1'b0;
    vif.als_data = '0;
    forever begin
      @(negedge clk);
      if (stale_left > 0) begin
        stale_left--;
        if (stale_left == 0) vif.als_done = 1'b0;
      end else if (vif.als_done && vif.als_trigger !== 1'b1) begin
        if (rd_stale > 0) stale_left = rd_stale;
        else vif.als_done = 1'b0;
      end else if (vif.als_trigger === 1'b1 && !vif.als_done && !rd_never) begin
        age++;
        if (age >= RD_DELAY) begin
          v = (rd_q.size() > 0) ? rd_q.pop_front() : 8'($urandom);
          vif.als_data = {24'hFFFFFF, v};
          vif.als_done = 1'b1;
          served++;
          age = 0;
          grp.push_back(int'(v));
          if (grp.size() == 4) begin
            sum = 0;
            foreach (grp[i]) sum += grp[i];
            exp_q.push_back(sum / 4);
            grp.delete();
          end
        end
      end
      if (vif.als_trigger !== 1'b1) age = 0;
    end
  end
  // every avg_valid must match the mean of the last four served samples and the hysteresis rule
  initial begin
    int e, t, hi;
    forever begin
      @(negedge clk);
      if (vif.avg_valid === 1'b1) begin
        chk("avg_valid_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          t = int'(vif.threshold);
          hi = (t + 4 > 255) ? 255 : t + 4;
          if (e < t) m_dark = 1'b1;
          else if (e >= hi) m_dark = 1'b0;
          chk("avg_model", 32'(vif.avg), 32'(e));
          chk("dark_model", 32'(vif.dark), 32'(m_dark));
        end
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end
  initial begin
    int n, s0;
    rst = 1'b0;
    vif.enable = 1'b1;
    vif.threshold = 8'h30;
    vif.clear_err = 1'b0;
    rd_q.push_back(8'h10);
    rd_q.push_back(8'h20);
    rd_q.push_back(8'h30);
    rd_q.push_back(8'h41);
    repeat (3) @(negedge clk);
    chk("rst_trigger", 32'(vif.als_trigger), 32'd0);
    chk("rst_oe", 32'(vif.als_oe), 32'd0);
    chk("rst_avg", 32'(vif.avg), 32'd0);
    chk("rst_avg_valid", 32'(vif.avg_valid), 32'd0);
    chk("rst_dark", 32'(vif.dark), 32'd0);
    chk("rst_timeout_err", 32'(vif.timeout_err), 32'd0);
    rst = 1'b1;
    wait_for(S_TRIG, 1'b1, 5, n);
    chk("rst_release_trigger_within_2", 32'(n >= 1 && n <= 2), 32'd1);
    wait_for(S_AVG, 1'b1, 600, n);
    chk("avg1_pulse", 32'(n < 600), 32'd1);
    chk("avg1_after_four_samples", 32'(served), 32'd4);
    chk("avg1_value", 32'(vif.avg), 32'h28);
    chk("avg1_dark", 32'(vif.dark), 32'd1);
    wait_for(S_TRIG, 1'b1, 100, n);
    chk("period_after_avg", 32'(n), 32'd50);
    avg_group(8'h32, 8'h32, 8'h32, 8'h32, "hyst_32");
    chk("hyst_32_dark_holds", 32'(vif.dark), 32'd1);
    avg_group(8'h33, 8'h35, 8'h34, 8'h34, "hyst_34");
    chk("hyst_34_dark_clears", 32'(vif.dark), 32'd0);
    vif.threshold = 8'hFE;
    avg_group(8'h10, 8'h10, 8'h10, 8'h10, "sat_low");
    chk("sat_low_dark_sets", 32'(vif.dark), 32'd1);
    avg_group(8'hFE, 8'hFE, 8'hFE, 8'hFE, "sat_fe");
    chk("sat_fe_dark_holds", 32'(vif.dark), 32'd1);
    avg_group(8'hFF, 8'hFF, 8'hFF, 8'hFF, "sat_ff");
    chk("sat_ff_dark_clears", 32'(vif.dark), 32'd0);
    for (int g = 0; g < 3; g++) begin
      vif.threshold = 8'($urandom);
      avg_group(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), "random");
    end
    rd_never = 1'b1;
    wait_for(S_TRIG, 1'b1, 100, n);
    chk("to_trigger_rise", 32'(n < 100), 32'd1);
    wait_for(S_TRIG, 1'b0, 100, n);
    chk("to_trigger_width", 32'(n), 32'd40);
    chk("to_err_set", 32'(vif.timeout_err), 32'd1);
    wait_for(S_TRIG, 1'b1, 100, n);
    chk("to_retrigger_period", 32'(n), 32'd50);
    repeat (39) @(negedge clk);
    vif.clear_err = 1'b1;
    @(negedge clk);
    chk("to2_trigger_fell", 32'(vif.als_trigger), 32'd0);
    chk("to2_set_beats_clear", 32'(vif.timeout_err), 32'd1);
    @(negedge clk);
    vif.clear_err = 1'b0;
    chk("clear_err_clears", 32'(vif.timeout_err), 32'd0);
    rd_never = 1'b0;
    wait_for(S_TRIG, 1'b1, 100, n);
    chk("drop_trigger_rise", 32'(n < 100), 32'd1);
    repeat (5) @(negedge clk);
    vif.enable = 1'b0;
    s0 = served;
    wait_for(S_OE, 1'b1, 40, n);
    chk("drop_read_completes", 32'(n < 40), 32'd1);
    chk("drop_sample_served", 32'(served - s0), 32'd1);
    wait_for(S_TRIG, 1'b1, 150, n);
    chk("drop_goes_idle", 32'(n), 32'd150);
    grp.delete();
    s0 = served;
    vif.enable = 1'b1;
    avg_group(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), "reenable");
    chk("reenable_four_fresh", 32'(served - s0), 32'd4);
    rd_stale = 80;
    wait_for(S_TRIG, 1'b1, 100, n);
    wait_for(S_TRIG, 1'b0, 40, n);
    chk("stale_first_read", 32'(n < 40), 32'd1);
    wait_for(S_TRIG, 1'b1, 100, n);
    chk("stale_retrigger", 32'(n), 32'd53);
    s0 = served;
    repeat (10) @(negedge clk);
    rd_stale = 0;
    chk("stale_waits_trigger", 32'(vif.als_trigger), 32'd1);
    chk("stale_no_oe", 32'(vif.als_oe), 32'd0);
    wait_for(S_OE, 1'b1, 100, n);
    chk("stale_capture_seen", 32'(n < 100), 32'd1);
    chk("stale_capture_fresh", 32'(served - s0), 32'd1);
    wait_for(S_TRIG, 1'b1, 100, n);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_trigger", 32'(vif.als_trigger), 32'd0);
    chk("midrst_avg", 32'(vif.avg), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("all_averages_seen", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
